// File: rtl/neuron_core_tm.sv
// Time-multiplexed integrate/leak/fire core: one shared datapath sweeps every neuron and axon.
// Build option NEURON_CORE_SAT_EN: saturating arithmetic; undefined: two's-complement wrap.
//
// state    | meaning
// ST_IDLE  | waiting for START, host owns the arrays
// ST_INTEG | accumulate one axon per cycle for neuron n
// ST_LEAK  | add the neuron's leak
// ST_FIRE  | threshold compare, potential update, advance to the next neuron
module neuron_core_tm #(
  parameter int          NUM_AXONS   = 256,
  parameter int          NUM_NEURONS = 256,
  parameter int          NUM_WEIGHTS = 4,
  parameter int          DATA_WIDTH  = 9,
  parameter logic [31:0] CORE_BASE   = 32'h8000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        busy_o,
  output logic        done_o
);
  localparam int DW = DATA_WIDTH;
  localparam int AB = $clog2(NUM_AXONS);
  localparam int NB = $clog2(NUM_NEURONS);
  localparam logic [17:0] AW18 = 18'(NUM_AXONS / 32);
  localparam logic [17:0] NW18 = 18'(NUM_NEURONS / 32);
  localparam logic [17:0] TW18 = 18'(NUM_AXONS / 16);
  localparam logic [17:0] PW18 = 18'(4 * NUM_NEURONS);
  localparam logic [17:0] CW18 = 18'(NUM_NEURONS * (NUM_AXONS / 32));
  localparam logic [AB-1:0] A_LAST = AB'(NUM_AXONS - 1);
  localparam logic [AB-1:0] A_ONE  = AB'(1);
  localparam logic [NB-1:0] N_LAST = NB'(NUM_NEURONS - 1);
  localparam logic [NB-1:0] N_ONE  = NB'(1);
`ifdef NEURON_CORE_SAT_EN
  localparam logic signed [DW:0] MAXV = (DW+1)'((1 << (DW - 1)) - 1);
  localparam logic signed [DW:0] MINV = (DW+1)'(-(1 << (DW - 1)));
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_INTEG, ST_LEAK, ST_FIRE} state_t;

  function automatic logic signed [DW:0] sx1(input logic signed [DW-1:0] v);
    return (DW+1)'(v);
  endfunction

  function automatic logic [9:0] sx10(input logic signed [DW-1:0] v);
    return 10'(v);
  endfunction

  function automatic logic signed [DW:0] narrow(input logic signed [DW:0] x);
`ifdef NEURON_CORE_SAT_EN
    if (x > MAXV)      return MAXV;
    else if (x < MINV) return MINV;
    else               return x;
`else
    return sx1(x[DW-1:0]);
`endif
  endfunction

  state_t              state;
  logic [NB-1:0]       n;
  logic [AB-1:0]       a;
  logic signed [DW:0]  acc;
  logic                start_q;

  logic [NUM_AXONS-1:0]   spike_in;
  logic [NUM_NEURONS-1:0] spike_out;
  logic [2*NUM_AXONS-1:0] types;
  logic [NUM_AXONS-1:0]   conn [NUM_NEURONS];
  logic signed [DW-1:0]   leak [NUM_NEURONS];
  logic signed [DW-1:0]   pos_th [NUM_NEURONS];
  logic signed [DW-1:0]   neg_th [NUM_NEURONS];
  logic signed [DW-1:0]   reset_pot [NUM_NEURONS];
  logic signed [DW-1:0]   potential [NUM_NEURONS];
  logic signed [DW-1:0]   wt [NUM_NEURONS][NUM_WEIGHTS];
  logic [NUM_NEURONS-1:0] reset_mode;

  logic [17:0]   off, in_rel, out_rel, typ_rel, par_rel, con_rel;
  logic          hit, sel_ctrl, sel_in, sel_out, sel_typ, sel_par, sel_con;
  logic [AB-1:0] in_base, con_base;
  logic [AB:0]   typ_base;
  logic [NB-1:0] out_base, par_n, con_n;
  logic [1:0]    par_w;
  logic [31:0]   rd_word, wr_word, byte_mask;
  logic          acc_go, eng_busy, host_wr;
  logic          unused_bits;

  assign unused_bits = ^wbs_adr_i[1:0];
  assign off         = wbs_adr_i[19:2];
  assign hit         = (wbs_adr_i[31:20] == CORE_BASE[31:20]);
  assign byte_mask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  always_comb begin
    in_rel   = off - 18'h00100;
    out_rel  = off - 18'h00200;
    typ_rel  = off - 18'h00300;
    par_rel  = off - 18'h04000;
    con_rel  = off - 18'h10000;
    sel_ctrl = (off == 18'h0);
    sel_in   = (off >= 18'h00100) && (in_rel  < AW18);
    sel_out  = (off >= 18'h00200) && (out_rel < NW18);
    sel_typ  = (off >= 18'h00300) && (typ_rel < TW18);
    sel_par  = (off >= 18'h04000) && (par_rel < PW18);
    sel_con  = (off >= 18'h10000) && (con_rel < CW18);
    in_base  = AB'({in_rel, 5'b0});
    out_base = NB'({out_rel, 5'b0});
    typ_base = (AB+1)'({typ_rel, 5'b0});
    par_n    = NB'(par_rel >> 2);
    par_w    = par_rel[1:0];
    con_n    = NB'(con_rel / AW18);
    con_base = AB'({con_rel % AW18, 5'b0});

    rd_word = '0;
    if (sel_ctrl)     rd_word = {30'b0, done_o, busy_o};
    else if (sel_in)  rd_word = spike_in[in_base +: 32];
    else if (sel_out) rd_word = spike_out[out_base +: 32];
    else if (sel_typ) rd_word = types[typ_base +: 32];
    else if (sel_par) begin
      case (par_w)
        2'd0:    rd_word = {1'b0, reset_mode[par_n], sx10(neg_th[par_n]), sx10(pos_th[par_n]),
                            sx10(leak[par_n])};
        2'd1:    rd_word = {2'b0, sx10(wt[par_n][2]), sx10(wt[par_n][1]), sx10(wt[par_n][0])};
        2'd2:    rd_word = {12'b0, sx10(reset_pot[par_n]), sx10(wt[par_n][3])};
        default: rd_word = {22'b0, sx10(potential[par_n])};
      endcase
    end
    else if (sel_con) rd_word = conn[con_n][con_base +: 32];

    // partial-byte writes merge into the word as it currently reads back
    wr_word = (rd_word & ~byte_mask) | (wbs_dat_i & byte_mask);
  end

  assign acc_go   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & hit;
  assign eng_busy = (state != ST_IDLE) | start_q;
  assign host_wr  = acc_go & wbs_we_i & ~eng_busy;

  logic [1:0]         ax_type;
  logic               ax_on;
  logic signed [DW:0] integ_sum, leak_sum, fire_sub;

  always_comb begin
    ax_type   = types[{a, 1'b0} +: 2];
    ax_on     = spike_in[a] & conn[n][a];
    integ_sum = narrow(acc + sx1(wt[n][ax_type]));
    leak_sum  = narrow(acc + sx1(leak[n]));
    fire_sub  = narrow(acc - sx1(pos_th[n]));
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state      <= ST_IDLE;
      n          <= '0;
      a          <= '0;
      acc        <= '0;
      start_q    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      spike_in   <= '0;
      spike_out  <= '0;
      types      <= '0;
      reset_mode <= '0;
      conn       <= '{default: '0};
      leak       <= '{default: '0};
      pos_th     <= '{default: '0};
      neg_th     <= '{default: '0};
      reset_pot  <= '{default: '0};
      potential  <= '{default: '0};
      wt         <= '{default: '0};
    end else begin
      wbs_ack_o <= acc_go;
      wbs_dat_o <= (acc_go && !wbs_we_i) ? rd_word : '0;
      start_q   <= acc_go && wbs_we_i && sel_ctrl && wbs_sel_i[0] && wbs_dat_i[0] && !eng_busy;

      if (host_wr) begin
        if (sel_in)       spike_in[in_base +: 32] <= wr_word;
        else if (sel_typ) types[typ_base +: 32]   <= wr_word;
        else if (sel_par) begin
          case (par_w)
            2'd0: begin
              leak[par_n]       <= wr_word[DW-1:0];
              pos_th[par_n]     <= wr_word[10 +: DW];
              neg_th[par_n]     <= wr_word[20 +: DW];
              reset_mode[par_n] <= wr_word[30];
            end
            2'd1: begin
              wt[par_n][0] <= wr_word[DW-1:0];
              wt[par_n][1] <= wr_word[10 +: DW];
              wt[par_n][2] <= wr_word[20 +: DW];
            end
            2'd2: begin
              wt[par_n][3]     <= wr_word[DW-1:0];
              reset_pot[par_n] <= wr_word[10 +: DW];
            end
            default: potential[par_n] <= wr_word[DW-1:0];
          endcase
        end
        else if (sel_con) conn[con_n][con_base +: 32] <= wr_word;
      end

      case (state)
        ST_IDLE: begin
          if (start_q) begin
            spike_out <= '0;
            done_o    <= 1'b0;
            busy_o    <= 1'b1;
            n         <= '0;
            a         <= '0;
            acc       <= sx1(potential[0]);
            state     <= ST_INTEG;
          end
        end
        ST_INTEG: begin
          if (ax_on) acc <= integ_sum;
          if (a == A_LAST) state <= ST_LEAK;
          else             a     <= a + A_ONE;
        end
        ST_LEAK: begin
          acc   <= leak_sum;
          state <= ST_FIRE;
        end
        default: begin
          if (acc >= sx1(pos_th[n])) begin
            spike_out[n] <= 1'b1;
            potential[n] <= reset_mode[n] ? fire_sub[DW-1:0] : reset_pot[n];
          end else if (acc < sx1(neg_th[n])) begin
            potential[n] <= neg_th[n];
          end else begin
            potential[n] <= acc[DW-1:0];
          end
          if (n == N_LAST) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            n     <= n + N_ONE;
            a     <= '0;
            acc   <= sx1(potential[n + N_ONE]);
            state <= ST_INTEG;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_core_tm.sv
// Bench for neuron_core_tm (32 neurons x 32 axons, 9-bit data): register table, directed sweeps,
// random sweeps against an arithmetic reference model, latency, busy behaviour and mid-sweep reset.
module tb_neuron_core_tm;
  localparam int NA = 32;
  localparam int NN = 32;
  localparam int DW = 9;
  localparam int LAT = NN * (NA + 2) + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i, dat_o;
  logic        ack, busy, done;

  always #5 clk = ~clk;

  neuron_core_tm #(
    .NUM_AXONS(NA), .NUM_NEURONS(NN), .NUM_WEIGHTS(4), .DATA_WIDTH(DW), .CORE_BASE(32'h8000_0000)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .busy_o(busy), .done_o(done)
  );

  int errors = 0;
  int checks = 0;
  int unsigned cycle_cnt = 0;
  always @(posedge clk) cycle_cnt++;

  // reference model state
  int          m_leak[NN], m_pos[NN], m_neg[NN], m_rm[NN], m_rp[NN], m_pot[NN];
  int          m_wt[NN][4];
  int          m_typ[NA];
  logic [31:0] m_conn[NN];
  logic [31:0] m_spk;
  logic [31:0] m_out;

  typedef struct {
    logic [17:0] off;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int nar(input int x);
    int m;
`ifdef NEURON_CORE_SAT_EN
    if (x > 255) return 255;
    if (x < -256) return -256;
    return x;
`else
    m = x & 511;
    if (m >= 256) m = m - 512;
    return m;
`endif
  endfunction

  function automatic logic [9:0] f10(input int v);
    return v[9:0];
  endfunction

  task automatic model_sweep();
    int acc;
    m_out = '0;
    for (int n = 0; n < NN; n++) begin
      acc = m_pot[n];
      for (int a = 0; a < NA; a++)
        if (m_spk[a] && m_conn[n][a]) acc = nar(acc + m_wt[n][m_typ[a]]);
      acc = nar(acc + m_leak[n]);
      if (acc >= m_pos[n]) begin
        m_out[n] = 1'b1;
        m_pot[n] = (m_rm[n] != 0) ? nar(acc - m_pos[n]) : m_rp[n];
      end else if (acc < m_neg[n]) m_pot[n] = m_neg[n];
      else m_pot[n] = acc;
    end
  endtask

  task automatic clear_model();
    for (int n = 0; n < NN; n++) begin
      m_leak[n] = 0; m_pos[n] = 0; m_neg[n] = 0; m_rm[n] = 0; m_rp[n] = 0; m_pot[n] = 0;
      m_conn[n] = '0;
      for (int w = 0; w < 4; w++) m_wt[n][w] = 0;
    end
    for (int a = 0; a < NA; a++) m_typ[a] = 0;
    m_spk = '0;
  endtask

  task automatic wb_access(input logic [17:0] off, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] q);
    logic got;
    got = 1'b0;
    q   = '0;
    @(posedge clk); #1;
    adr = 32'h8000_0000 | {12'b0, off, 2'b00};
    we = w; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; q = dat_o; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL wb_ack_timeout off=%h actual=no_ack expected=ack", off);
    end
  endtask

  task automatic wr(input logic [17:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] q;
    wb_access(off, 1'b1, d, s, q);
  endtask

  task automatic rd(input logic [17:0] off, output logic [31:0] q);
    wb_access(off, 1'b0, 32'h0, 4'hF, q);
  endtask

  task automatic program_dut();
    logic [31:0] tw0, tw1;
    tw0 = '0; tw1 = '0;
    for (int a = 0; a < 16; a++) begin
      tw0[a*2 +: 2] = m_typ[a][1:0];
      tw1[a*2 +: 2] = m_typ[a+16][1:0];
    end
    wr(18'h00100, m_spk, 4'hF);
    wr(18'h00300, tw0, 4'hF);
    wr(18'h00301, tw1, 4'hF);
    for (int n = 0; n < NN; n++) begin
      wr(18'(32'h10000 + n), m_conn[n], 4'hF);
      wr(18'(32'h4000 + 4*n), {1'b0, m_rm[n][0], f10(m_neg[n]), f10(m_pos[n]), f10(m_leak[n])}, 4'hF);
      wr(18'(32'h4000 + 4*n + 1), {2'b0, f10(m_wt[n][2]), f10(m_wt[n][1]), f10(m_wt[n][0])}, 4'hF);
      wr(18'(32'h4000 + 4*n + 2), {12'b0, f10(m_rp[n]), f10(m_wt[n][3])}, 4'hF);
      wr(18'(32'h4000 + 4*n + 3), {22'b0, f10(m_pot[n])}, 4'hF);
    end
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * LAT; i++) begin
      @(posedge clk); #1;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] q;
    rd(18'h00200, q);
    chk({tag, "_spikes"}, q, m_out);
    for (int n = 0; n < NN; n++) begin
      rd(18'(32'h4000 + 4*n + 3), q);
      chk($sformatf("%s_pot%0d", tag, n), q, {22'b0, f10(m_pot[n])});
    end
  endtask

  task automatic run_sweep(input string tag);
    logic ok;
    wr(18'h0, 32'h1, 4'hF);
    wait_done(ok);
    chk({tag, "_done_seen"}, {31'b0, ok}, 32'h1);
    model_sweep();
    compare_all(tag);
  endtask

  task automatic neuron0_base();
    clear_model();
    m_conn[0] = 32'h0000000F;
    m_wt[0][0] = 20;
    m_pos[0] = 50;
    m_spk = 32'h0000000F;
  endtask

  task automatic randomize_model();
    for (int n = 0; n < NN; n++) begin
      m_leak[n] = int'($urandom_range(0, 40)) - 20;
      m_pos[n]  = int'($urandom_range(0, 255)) - 40;
      m_neg[n]  = int'($urandom_range(0, 200)) - 220;
      m_rm[n]   = int'($urandom_range(0, 1));
      m_rp[n]   = int'($urandom_range(0, 60)) - 30;
      m_pot[n]  = int'($urandom_range(0, 511)) - 256;
      m_conn[n] = $urandom;
      for (int w = 0; w < 4; w++) m_wt[n][w] = int'($urandom_range(0, 511)) - 256;
    end
    for (int a = 0; a < NA; a++) m_typ[a] = int'($urandom_range(0, 3));
    m_spk = $urandom;
  endtask

  initial begin
    logic [31:0] q;
    logic        ok;
    int unsigned t0;

    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_i = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    rst_n = 1'b1;
    rd(18'h0, q);         chk("rst_ctrl", q, 32'h0);
    rd(18'h04003, q);     chk("rst_pot0", q, 32'h0);
    rd(18'h00200, q);     chk("rst_out", q, 32'h0);

    vt[0]  = '{18'h00100, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
    vt[1]  = '{18'h00100, 32'h00000011, 4'h1, 32'hDEADBE11};
    vt[2]  = '{18'h00101, 32'hFFFFFFFF, 4'hF, 32'h00000000};
    vt[3]  = '{18'h00200, 32'hFFFFFFFF, 4'hF, 32'h00000000};
    vt[4]  = '{18'h00300, 32'h12345678, 4'hF, 32'h12345678};
    vt[5]  = '{18'h00302, 32'hFFFFFFFF, 4'hF, 32'h00000000};
    vt[6]  = '{18'h04014, 32'hFFFFFFFF, 4'hF, 32'h7FFFFFFF};
    vt[7]  = '{18'h04015, 32'h000000FF, 4'hF, 32'h000000FF};
    vt[8]  = '{18'h04015, 32'h00000100, 4'hF, 32'h00000300};
    vt[9]  = '{18'h04016, 32'hFFFFFFFF, 4'hF, 32'h000FFFFF};
    vt[10] = '{18'h04017, 32'h00000200, 4'hF, 32'h00000000};
    vt[11] = '{18'h04017, 32'h0000007B, 4'hF, 32'h0000007B};
    vt[12] = '{18'h10003, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5};
    vt[13] = '{18'h10003, 32'h00000000, 4'h8, 32'h00A5A5A5};
    vt[14] = '{18'h040A0, 32'hFFFFFFFF, 4'hF, 32'h00000000};
    vt[15] = '{18'h04014, 32'h00000000, 4'h1, 32'h7FFFFF00};
    vt[16] = '{18'h10020, 32'hFFFFFFFF, 4'hF, 32'h00000000};
    vt[17] = '{18'h00000, 32'h00000000, 4'hF, 32'h00000000};
    for (int i = 0; i < 18; i++) begin
      wr(vt[i].off, vt[i].wd, vt[i].sel);
      rd(vt[i].off, q);
      chk($sformatf("reg_vec%0d", i), q, vt[i].exp);
    end

    // directed sweeps
    neuron0_base();
    program_dut();
    run_sweep("s1");
    rd(18'h00200, q);   chk("s1_spike_n0", {31'b0, q[0]}, 32'h1);
    rd(18'h04003, q);   chk("s1_pot_n0", q, 32'h0);

    neuron0_base();
    m_rm[0] = 1;
    program_dut();
    run_sweep("s2");
    rd(18'h04003, q);   chk("s2_pot_n0", q, 32'h0000001E);

    neuron0_base();
    m_spk = '0; m_neg[0] = -10; m_leak[0] = -15;
    program_dut();
    run_sweep("s3");
    rd(18'h00200, q);   chk("s3_spike_n0", {31'b0, q[0]}, 32'h0);
    rd(18'h04003, q);   chk("s3_pot_n0", q, 32'h000003F6);

    clear_model();
    m_pot[0] = 250; m_wt[0][0] = 10; m_conn[0] = 32'h1; m_spk = 32'h1;
    m_pos[0] = 255; m_neg[0] = -256;
    program_dut();
    run_sweep("s4");
    rd(18'h00200, q);
`ifdef NEURON_CORE_SAT_EN
    chk("s4_spike_n0", {31'b0, q[0]}, 32'h1);
    rd(18'h04003, q);   chk("s4_pot_n0", q, 32'h0);
`else
    chk("s4_spike_n0", {31'b0, q[0]}, 32'h0);
    rd(18'h04003, q);   chk("s4_pot_n0", q, 32'h00000304);
`endif

    // random sweeps; potentials carry over between sweeps, only spikes change
    randomize_model();
    program_dut();
    for (int it = 0; it < 3; it++) begin
      if (it > 0) begin
        m_spk = $urandom;
        wr(18'h00100, m_spk, 4'hF);
      end
      run_sweep($sformatf("rnd%0d", it));
    end

    // latency, reads while busy, dropped writes and ignored START
    m_spk = $urandom;
    wr(18'h00100, m_spk, 4'hF);
    wr(18'h0, 32'h1, 4'hF);
    t0 = cycle_cnt;
    rd(18'h0, q);        chk("busy_ctrl", q, 32'h1);
    wr(18'h00100, ~m_spk, 4'hF);
    wr(18'h04003, 32'h55, 4'hF);
    repeat (50) @(posedge clk);
    wr(18'h0, 32'h1, 4'hF);
    wait_done(ok);
    chk("lat_done_seen", {31'b0, ok}, 32'h1);
    chk("latency", cycle_cnt - t0, LAT);
    rd(18'h0, q);        chk("done_ctrl", q, 32'h2);
    rd(18'h00100, q);    chk("busy_write_dropped", q, m_spk);
    model_sweep();
    compare_all("lat");

    // reset mid-sweep
    wr(18'h0, 32'h1, 4'hF);
    repeat (200) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_done", {31'b0, done}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    chk("midrst_done_stays0", {31'b0, done}, 32'h0);
    rd(18'h0, q);        chk("midrst_ctrl", q, 32'h0);
    rd(18'h00200, q);    chk("midrst_out", q, 32'h0);
    rd(18'h00100, q);    chk("midrst_in", q, 32'h0);
    for (int n = 0; n < 4; n++) begin
      rd(18'(32'h4000 + 4*n + 3), q);
      chk($sformatf("midrst_pot%0d", n), q, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
